// File: rtl/fir_decim_n_pkg.sv
// Shared defaults and sizing helpers for the decimating FIR stages of the FM radio chain.
package fir_decim_n_pkg;

   localparam int unsigned DataWidthDefault = 32;
   localparam int unsigned NumTapsDefault   = 32;
   localparam int unsigned DecimDefault     = 8;
   localparam int unsigned QuantBitsDefault = 10;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_decim_n_mac.sv
// Time-shared multiply/dequantise/accumulate unit: one coefficient-sample product per enabled cycle.
module fir_decim_n_mac
   import fir_decim_n_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DataWidthDefault,
   parameter int unsigned QUANT_BITS = QuantBitsDefault
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic        [DATA_WIDTH-1:0] acc
);

   localparam int unsigned ProdW = 2 * DATA_WIDTH;

   logic signed [ProdW-1:0]      a_ext;
   logic signed [ProdW-1:0]      b_ext;
   logic signed [ProdW-1:0]      prod;
   logic        [DATA_WIDTH-1:0] deq;
   logic        [DATA_WIDTH-1:0] acc_q;
   logic        [DATA_WIDTH-1:0] acc_d;

   assign a_ext = ProdW'(a);
   assign b_ext = ProdW'(b);
   assign prod  = a_ext * b_ext;
   // Arithmetic shift floors toward -inf; the high product bits are dropped.
   assign deq   = DATA_WIDTH'(prod >>> QUANT_BITS);

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + deq;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_decim_n.sv
// Decimating FIR stage: pops DECIM samples per group, runs NUM_TAPS MAC cycles, writes one result.
module fir_decim_n
   import fir_decim_n_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DataWidthDefault,
   parameter int unsigned NUM_TAPS   = NumTapsDefault,
   parameter int unsigned DECIM      = DecimDefault,
   parameter int unsigned QUANT_BITS = QuantBitsDefault,
   parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: '0}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_dout,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   output logic [DATA_WIDTH-1:0] out_din,
   input  logic                  out_full,
   output logic                  out_wr_en
);

   typedef enum logic [1:0] {S_FILL, S_MAC, S_WRITE} fir_state_t;

   localparam int unsigned TapW = idx_width(NUM_TAPS);
   localparam int unsigned CntW = $clog2(DECIM + 1);
   localparam logic [TapW-1:0] LastTap = TapW'(NUM_TAPS - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DECIM - 1);

   if (DECIM < 1 || DECIM > NUM_TAPS) begin : g_bad_decim
      $error("fir_decim_n: DECIM must lie in 1..NUM_TAPS");
   end
   if (QUANT_BITS >= 2 * DATA_WIDTH) begin : g_bad_quant
      $error("fir_decim_n: QUANT_BITS must be below the product width");
   end

   fir_state_t state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [TapW-1:0] tap_q, tap_d;
   logic [DATA_WIDTH-1:0] sr_q [NUM_TAPS];

   logic pop;
   logic mac_clr;
   logic mac_en;
   logic signed [DATA_WIDTH-1:0] coef_sel;
   logic signed [DATA_WIDTH-1:0] samp_sel;
   logic        [DATA_WIDTH-1:0] mac_acc;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tap_d     = tap_q;
      pop       = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      out_wr_en = 1'b0;
      unique case (state_q)
         S_FILL: begin
            // Gated by reset so the handshakes stay low while reset is held.
            pop = reset && !in_empty;
            if (pop) begin
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  tap_d   = '0;
                  mac_clr = 1'b1;
                  state_d = S_MAC;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (tap_q == LastTap) begin
               state_d = S_WRITE;
            end else begin
               tap_d = tap_q + TapW'(1);
            end
         end
         S_WRITE: begin
            out_wr_en = reset && !out_full;
            if (out_wr_en) begin
               state_d = S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   assign in_rd_en = pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tap_q   <= tap_d;
      end
   end

   // sr_q[0] is the newest sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            sr_q[k] <= '0;
         end
      end else if (pop) begin
         sr_q[0] <= in_dout;
         for (int k = 1; k < NUM_TAPS; k++) begin
            sr_q[k] <= sr_q[k-1];
         end
      end
   end

   assign coef_sel = COEFFS[tap_q];
   assign samp_sel = sr_q[tap_q];

   fir_decim_n_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .QUANT_BITS (QUANT_BITS)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (coef_sel),
      .b     (samp_sel),
      .acc   (mac_acc)
   );

   // The accumulator holds the finished sum from the last tap until the next group starts.
   assign out_din = mac_acc;

endmodule
